// File: rtl/dm_pkg.sv
// Shared definitions for the byte-addressable data memory: access sizes,
// FSM states and the byte-enable helper.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Byte enables for an access of the given size starting at byte lane 'lane'.
  // Always 8 lanes wide; callers with a 32-bit word keep the low 4 bits.
  function automatic logic [7:0] byte_en(input logic [1:0] size, input logic [2:0] lane);
    logic [7:0] base;
    case (size)
      SZ_BYTE: base = 8'h01;
      SZ_HALF: base = 8'h03;
      SZ_WORD: base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << lane;
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane steering: store-side byte enables and data
// replication, load-side lane extraction with sign/zero extension.
module dm_lane_align
  import dm_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        i_st_size,
  input  logic [2:0]        i_st_lane,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W/8-1:0] o_be,
  output logic [DATA_W-1:0] o_wdata,
  input  logic [1:0]        i_ld_size,
  input  logic [2:0]        i_ld_lane,
  input  logic              i_ld_unsigned,
  input  logic [DATA_W-1:0] i_rword,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_mask;
  logic              w_sign;

  // Store path: enables for the addressed lanes, low bits replicated across the word
  always_comb begin
    o_be = NB'(byte_en(i_st_size, i_st_lane));
    case (i_st_size)
      SZ_BYTE: o_wdata = {NB{i_wdata[7:0]}};
      SZ_HALF: o_wdata = {(NB/2){i_wdata[15:0]}};
      SZ_WORD: o_wdata = {(NB/4){i_wdata[31:0]}};
      default: o_wdata = i_wdata;
    endcase
  end

  // Load path: bring the addressed lane down to bit 0, then mask and extend
  always_comb begin
    w_shift = i_rword >> {i_ld_lane, 3'b000};
    w_mask  = '1;
    w_sign  = w_shift[DATA_W-1];
    case (i_ld_size)
      SZ_BYTE: begin
        w_mask = DATA_W'(8'hFF);
        w_sign = w_shift[7];
      end
      SZ_HALF: begin
        w_mask = DATA_W'(16'hFFFF);
        w_sign = w_shift[15];
      end
      SZ_WORD: begin
        w_mask = DATA_W'(32'hFFFF_FFFF);
        w_sign = w_shift[31];
      end
      default: begin
        w_mask = '1;
        w_sign = w_shift[DATA_W-1];
      end
    endcase
    o_rdata = (w_shift & w_mask) | ((w_sign && !i_ld_unsigned) ? ~w_mask : '0);
  end

endmodule

// File: rtl/dm_byte_mem.sv
// Byte-addressable data memory with valid/ready requests, sized and
// extended loads, in-order responses after READ_LAT cycles, error
// reporting and a post-reset zero-clear sweep.
module dm_byte_mem
  import dm_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = 12,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int WIDX_W = ADDR_W - LANE_W;

  // Storage and control state
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rword;
  state_t            r_state;
  logic [IDX_W-1:0]  r_clear_ptr;
  logic              r_ready;
  logic              r_init_done;

  // First response stage (captured at the accept edge alongside the array read)
  logic              r_s1_valid;
  logic              r_s1_err;
  logic              r_s1_load;
  logic [1:0]        r_s1_size;
  logic              r_s1_uns;
  logic [2:0]        r_s1_lane;

  logic [WIDX_W-1:0] w_word_idx;
  logic [2:0]        w_lane;
  logic              w_range_err;
  logic              w_align_err;
  logic              w_err;
  logic              w_accept;
  logic              w_store;
  logic              w_clear;
  logic [NB-1:0]     w_st_be;
  logic [DATA_W-1:0] w_st_wdata;
  logic [DATA_W-1:0] w_ld_data;
  logic [DATA_W-1:0] w_s1_rdata;
  logic [IDX_W-1:0]  w_mem_addr;
  logic [NB-1:0]     w_mem_be;
  logic [DATA_W-1:0] w_mem_wdata;

  assign w_word_idx  = req_addr[ADDR_W-1:LANE_W];
  assign w_lane      = 3'(req_addr[LANE_W-1:0]);
  // Any index bit above the array's own index width means out of range
  assign w_range_err = |(w_word_idx >> IDX_W);
  assign w_err       = w_align_err || w_range_err;
  assign w_accept    = req_valid && r_ready;
  assign w_store     = w_accept && req_we && !w_err;
  assign w_clear     = (r_state == CLEAR) && rst_n;

  // The sweep owns the single array port until READY, so no arbitration is needed
  assign w_mem_addr  = w_clear ? r_clear_ptr : w_word_idx[IDX_W-1:0];
  assign w_mem_be    = w_clear ? '1 : (w_store ? w_st_be : '0);
  assign w_mem_wdata = w_clear ? '0 : w_st_wdata;

  assign req_ready   = r_ready;
  assign init_done   = r_init_done;

  // Natural alignment per access size; dwords do not exist on a 32-bit array
  always_comb begin
    case (req_size)
      SZ_BYTE: w_align_err = 1'b0;
      SZ_HALF: w_align_err = req_addr[0];
      SZ_WORD: w_align_err = |req_addr[1:0];
      default: w_align_err = (DATA_W == 32) || (|req_addr[2:0]);
    endcase
  end

  dm_lane_align #(.DATA_W(DATA_W)) u_align (
    .i_st_size     (req_size),
    .i_st_lane     (w_lane),
    .i_wdata       (req_wdata),
    .o_be          (w_st_be),
    .o_wdata       (w_st_wdata),
    .i_ld_size     (r_s1_size),
    .i_ld_lane     (r_s1_lane),
    .i_ld_unsigned (r_s1_uns),
    .i_rword       (r_rword),
    .o_rdata       (w_ld_data)
  );

  // Single-port byte-enabled array with registered read
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (w_mem_be[b]) r_mem[w_mem_addr][b*8 +: 8] <= w_mem_wdata[b*8 +: 8];
    end
    r_rword <= r_mem[w_mem_addr];
  end

  // CLEAR/READY sequencer: zero one word per cycle, then open the request port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      r_clear_ptr <= '0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_clear_ptr <= r_clear_ptr + IDX_W'(1);
          if (r_clear_ptr == IDX_W'(DEPTH - 1)) begin
            r_state     <= READY;
            r_ready     <= 1'b1;
            r_init_done <= 1'b1;
          end
        end
        default: begin
          r_ready     <= 1'b1;
          r_init_done <= 1'b1;
        end
      endcase
    end
  end

  // Capture request attributes needed to shape the response one cycle later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_load  <= 1'b0;
      r_s1_size  <= SZ_BYTE;
      r_s1_uns   <= 1'b0;
      r_s1_lane  <= 3'd0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_err   <= w_accept && w_err;
      r_s1_load  <= w_accept && !req_we;
      r_s1_size  <= req_size;
      r_s1_uns   <= req_unsigned;
      r_s1_lane  <= w_lane;
    end
  end

  // Stores and errors always return zero data
  assign w_s1_rdata = (r_s1_load && !r_s1_err) ? w_ld_data : '0;

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              r_s2_valid;
      logic              r_s2_err;
      logic [DATA_W-1:0] r_s2_rdata;

      // Extra response stage for the two-cycle latency configuration
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_s2_valid <= 1'b0;
          r_s2_err   <= 1'b0;
          r_s2_rdata <= '0;
        end else begin
          r_s2_valid <= r_s1_valid;
          r_s2_err   <= r_s1_err;
          r_s2_rdata <= w_s1_rdata;
        end
      end

      assign rsp_valid = r_s2_valid;
      assign rsp_err   = r_s2_err;
      assign rsp_rdata = r_s2_rdata;
    end else begin : g_lat1
      assign rsp_valid = r_s1_valid;
      assign rsp_err   = r_s1_err;
      assign rsp_rdata = w_s1_rdata;
    end
  endgenerate

endmodule

// File: tb/tb_dm_byte_mem.sv
// Self-checking bench for dm_byte_mem: table-driven requests checked by a
// response scoreboard, plus latency, reset-flush and sweep-restart sequences.
module tb_dm_byte_mem;
  import dm_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 8;
  localparam int LAT    = 2;
  localparam int NVEC   = 24;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              init_done;

  always #5 clk = ~clk;

  dm_byte_mem #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .READ_LAT(LAT), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .init_done(init_done)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    string       name;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acc;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  vec_t tbl[NVEC];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   n_rsp = 0;
  int   base;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every response must match the oldest outstanding request
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      n_rsp++;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 err=%0b rdata=%h, required no response",
                 rsp_err, rsp_rdata);
      end else begin
        mon_e = q.pop_front();
        if (rsp_err !== mon_e.err || rsp_rdata !== mon_e.rdata || cyc != mon_e.acc + LAT - 1) begin
          fails++;
          $display("FAIL %s: got err=%0b rdata=%h edge=%0d, required err=%0b rdata=%h edge=%0d",
                   mon_e.name, rsp_err, rsp_rdata, cyc + 1, mon_e.err, mon_e.rdata, mon_e.acc + LAT);
        end else begin
          $display("[TB] rsp %-14s err=%0b rdata=%h ok", mon_e.name, rsp_err, rsp_rdata);
        end
      end
    end
  end

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [7:0] addr, input logic [31:0] wdata,
                              input logic err, input logic [31:0] rdata, input string name);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.err = err; v.rdata = rdata; v.name = name;
    return v;
  endfunction

  task automatic issue(input vec_t v);
    exp_t e;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_%s: got req_ready=%b, required 1", v.name, req_ready);
    end
    req_valid    = 1'b1;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    e.err   = v.err;
    e.rdata = v.rdata;
    e.acc   = cyc + 1;
    e.name  = v.name;
    q.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain_%s: got %0d responses outstanding, required 0", tag, q.size());
      q.delete();
    end
  endtask

  // Called right after rst_n is released at a negedge
  task automatic check_sweep(input string tag);
    for (int k = 1; k <= DEPTH; k++) begin
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (req_ready !== (k == DEPTH) || init_done !== (k == DEPTH)) begin
        fails++;
        $display("FAIL sweep_%s: after edge %0d got req_ready=%b init_done=%b, required %b",
                 tag, k, req_ready, init_done, (k == DEPTH));
      end
    end
    $display("[TB] sweep %s checked over %0d cycles", tag, DEPTH);
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
        init_done !== 1'b0 || rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_%s: got ready=%b valid=%b err=%b done=%b rdata=%h, required all 0",
               tag, req_ready, rsp_valid, rsp_err, init_done, rsp_rdata);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_WORD;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

    tbl[0]  = mk(0, SZ_WORD, 0, 8'h3C, 32'h0,        0, 32'h0000_0000, "lw_3c_clear");
    tbl[1]  = mk(1, SZ_WORD, 0, 8'h10, 32'h11223344, 0, 32'h0,         "sw_10");
    tbl[2]  = mk(1, SZ_BYTE, 0, 8'h12, 32'h0000_00A5, 0, 32'h0,        "sb_12");
    tbl[3]  = mk(0, SZ_WORD, 0, 8'h10, 32'h0,        0, 32'h11A5_3344, "lw_10");
    tbl[4]  = mk(0, SZ_BYTE, 0, 8'h12, 32'h0,        0, 32'hFFFF_FFA5, "lb_12");
    tbl[5]  = mk(0, SZ_BYTE, 1, 8'h12, 32'h0,        0, 32'h0000_00A5, "lbu_12");
    tbl[6]  = mk(0, SZ_HALF, 0, 8'h10, 32'h0,        0, 32'h0000_3344, "lh_10_pos");
    tbl[7]  = mk(0, SZ_BYTE, 0, 8'h13, 32'h0,        0, 32'h0000_0011, "lb_13_pos");
    tbl[8]  = mk(1, SZ_HALF, 0, 8'h22, 32'hFFFF_8001, 0, 32'h0,        "sh_22");
    tbl[9]  = mk(0, SZ_HALF, 0, 8'h22, 32'h0,        0, 32'hFFFF_8001, "lh_22");
    tbl[10] = mk(0, SZ_HALF, 1, 8'h22, 32'h0,        0, 32'h0000_8001, "lhu_22");
    tbl[11] = mk(0, SZ_WORD, 0, 8'h20, 32'h0,        0, 32'h8001_0000, "lw_20");
    tbl[12] = mk(0, SZ_WORD, 0, 8'h06, 32'h0,        1, 32'h0,         "lw_06_misal");
    tbl[13] = mk(1, SZ_HALF, 0, 8'h11, 32'h0000_BEEF, 1, 32'h0,        "sh_11_misal");
    tbl[14] = mk(0, SZ_WORD, 0, 8'h10, 32'h0,        0, 32'h11A5_3344, "lw_10_again");
    tbl[15] = mk(0, SZ_WORD, 0, 8'h40, 32'h0,        1, 32'h0,         "lw_40_range");
    tbl[16] = mk(0, SZ_DWORD, 0, 8'h18, 32'h0,       1, 32'h0,         "ld_18_no64");
    tbl[17] = mk(1, SZ_BYTE, 0, 8'h3F, 32'h1234_5680, 0, 32'h0,        "sb_3f");
    tbl[18] = mk(0, SZ_WORD, 0, 8'h3C, 32'h0,        0, 32'h8000_0000, "lw_3c");
    tbl[19] = mk(1, SZ_WORD, 0, 8'h44, 32'hFFFF_FFFF, 1, 32'h0,        "sw_44_range");
    tbl[20] = mk(0, SZ_BYTE, 0, 8'h3F, 32'h0,        0, 32'hFFFF_FF80, "lb_3f");
    tbl[21] = mk(0, SZ_HALF, 1, 8'h3E, 32'h0,        0, 32'h0000_8000, "lhu_3e");
    tbl[22] = mk(1, SZ_WORD, 0, 8'h3C, 32'hCAFE_F00D, 0, 32'h0,        "sw_3c");
    tbl[23] = mk(0, SZ_WORD, 0, 8'h3C, 32'h0,        0, 32'hCAFE_F00D, "lw_3c_wf");

    repeat (3) @(negedge clk);
    check_reset_outputs("initial");
    rst_n = 1'b1;
    check_sweep("initial");

    // Table vectors issued back-to-back, one per cycle
    for (int i = 0; i < NVEC; i++) issue(tbl[i]);
    idle();
    drain("table");

    // Four back-to-back loads: exactly four in-order pulses at fixed latency
    base = n_rsp;
    issue(mk(0, SZ_WORD, 0, 8'h10, 32'h0, 0, 32'h11A5_3344, "b2b_lw_10"));
    issue(mk(0, SZ_WORD, 0, 8'h20, 32'h0, 0, 32'h8001_0000, "b2b_lw_20"));
    issue(mk(0, SZ_WORD, 0, 8'h3C, 32'h0, 0, 32'hCAFE_F00D, "b2b_lw_3c"));
    issue(mk(0, SZ_BYTE, 1, 8'h13, 32'h0, 0, 32'h0000_0011, "b2b_lbu_13"));
    idle();
    drain("b2b");
    repeat (3) @(negedge clk);
    tests++;
    if (n_rsp - base != 4) begin
      fails++;
      $display("FAIL b2b_count: got %0d rsp_valid pulses, required 4", n_rsp - base);
    end

    // Reset with responses in flight: the one already presented is seen, the rest are dropped
    issue(mk(0, SZ_WORD, 0, 8'h10, 32'h0, 0, 32'h11A5_3344, "flush_first"));
    issue(mk(0, SZ_WORD, 0, 8'h20, 32'h0, 0, 32'h8001_0000, "flush_dropped"));
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_reset_outputs("midstream");
    end
    rst_n = 1'b1;

    // Reset again partway through the sweep: it must restart from word 0
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("midsweep");
    rst_n = 1'b1;
    check_sweep("restart");

    issue(mk(0, SZ_WORD, 0, 8'h10, 32'h0, 0, 32'h0, "post_lw_10"));
    issue(mk(0, SZ_WORD, 0, 8'h20, 32'h0, 0, 32'h0, "post_lw_20"));
    issue(mk(0, SZ_WORD, 0, 8'h3C, 32'h0, 0, 32'h0, "post_lw_3c"));
    idle();
    drain("post");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dm_byte_mem.md
Name: dm_byte_mem

Overview:
- Parametrised successor to the single-cycle word data memory.
- Adds byte, halfword and word loads/stores with sign or zero extension, and a valid/ready request port.
- Adds an in-order response pipeline with configurable read latency, alignment and range error reporting, and a post-reset zero-clear sweep.
- Sits between the MEM stage of the MIPS core and the data array.

Parameters:
- DATA_W, 32: word width. Legal values are 32 or 64.
- DEPTH, 1024: number of words. Must be a power of 2.
- ADDR_W, 12: byte-address width. Must be ≥ log2(DEPTH) + log2(DATA_W/8).
- READ_LAT, 1: response latency in cycles after acceptance. Legal values are 1 or 2.
- CLEAR_ON_RESET, 1: when 1, zero the whole array after reset.

Ports:
- clk, input, 1: the single clock.
- rst_n, input, 1: synchronous active-low reset, sampled on the rising edge of clk.
- req_valid, input, 1: request present.
- req_ready, output, 1: block can accept a request this cycle.
- req_we, input, 1: 1 = store, 0 = load.
- req_size, input, 2: 0 byte, 1 half, 2 word, 3 dword. Size 3 is legal only when DATA_W=64.
- req_unsigned, input, 1: 1 = zero-extend loads, 0 = sign-extend loads.
- req_addr, input, ADDR_W: byte address.
- req_wdata, input, DATA_W: store data. Low-order bits are used for sub-word sizes.
- rsp_valid, output, 1: one-cycle pulse, one per accepted request.
- rsp_rdata, output, DATA_W: extended load data. 0 for stores and errors.
- rsp_err, output, 1: request was misaligned or out of range.
- init_done, output, 1: clear sweep finished.

Behaviour:
- Interface: clock clk, reset rst_n; one clock; reset is synchronous and active-low.
- Reset (rst_n low at a posedge):
  - state becomes CLEAR if CLEAR_ON_RESET=1, otherwise READY.
  - clear_ptr becomes 0.
  - req_ready, rsp_valid, rsp_err and init_done become 0; rsp_rdata becomes 0.
  - The response pipeline is flushed, so in-flight responses are dropped.
- Reset applied mid-sweep restarts the sweep from word 0.
- FSM states are CLEAR and READY.
- CLEAR:
  - Writes 0 to word clear_ptr each cycle and increments clear_ptr.
  - After the write to word DEPTH-1, moves to READY.
  - req_ready rises exactly DEPTH cycles after the first posedge with rst_n high.
  - init_done rises in the same cycle as req_ready and stays 1 until the next reset.
- READY:
  - req_ready = 1.
  - A request is accepted on a posedge where req_valid && req_ready.
  - Back-to-back acceptance every cycle is supported.
- Word index = req_addr >> log2(DATA_W/8). Lane = the low address bits.
- Byte lanes are little-endian: lane 0 is data[7:0].
- Error conditions (checked at acceptance):
  - half with addr[0] set;
  - word with addr[1:0] nonzero;
  - dword with addr[2:0] nonzero;
  - size 3 when DATA_W=32;
  - word index ≥ DEPTH.
- On error: no array write takes place; the response has rsp_err=1 and rsp_rdata=0.
- Store:
  - Generates byte enables for the addressed lanes.
  - The low 8/16/32/64 bits of req_wdata are replicated onto the selected lanes.
  - The array is written at the accept edge. Unselected bytes are unchanged.
- Load:
  - Reads the word, extracts the lanes and extends to DATA_W (sign or zero per req_unsigned).
- Response timing:
  - rsp_valid is asserted exactly READ_LAT cycles after the accept edge, for 1 cycle.
  - Responses are in order. There is no response backpressure.
- Hazards:
  - A store followed by a load of the same word in the next cycle returns the new data (write-first ordering).
  - The single port rules out any same-cycle read/write conflict.

Decomposition:
- Package dm_pkg holds:
  - size constants SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD;
  - state enum {CLEAR, READY};
  - a function returning byte enables for (size, lane).
- Sub-module dm_lane_align, purely combinational:
  - store path: byte-enable and write-data replication;
  - load path: lane extraction and sign/zero extension.
- dm_byte_mem holds the array, the FSM, clear_ptr and the READ_LAT pipeline.

Test Plan:
- Clear sweep (DEPTH=16): release rst_n → req_ready=0 for 16 cycles, then 1 with init_done=1; lw at addr 0x3C → rdata 0x00000000.
- Byte store and signed/unsigned loads:
  - sw 0x11223344 @0x10;
  - sb 0xA5 @0x12;
  - lw @0x10 → 0x11A53344;
  - lb @0x12 → 0xFFFFFFA5;
  - lbu @0x12 → 0x000000A5.
- Halfword: sh 0x8001 @0x22, then:
  - lh @0x22 → 0xFFFF8001;
  - lhu @0x22 → 0x00008001;
  - lw @0x20 → 0x80010000.
- Errors:
  - lw @0x06 → rsp_err=1, rdata=0;
  - sh @0x11 → rsp_err=1, and a following lw @0x10 is unchanged;
  - lw at word index DEPTH → rsp_err=1.
- Latency and ordering: READ_LAT=2, 4 back-to-back loads → exactly 4 rsp_valid pulses, each 2 cycles after its accept, in order; sw then lw of the same word on the next cycle → new data.
- Reset mid-stream: assert rst_n=0 with 2 responses pending → no rsp_valid afterwards; the clear sweep restarts from 0.
